// File: rtl/lpc_host_io.sv
// rtl/lpc_host_io.sv - LPC host initiator for single-byte I/O read/write cycles
//
// Purpose: issues one LPC I/O read or write per accepted request, drives LFRAME#
// and the AD nibbles, then follows the peripheral's SYNC/data/turnaround and
// reports completion. Long stalls, missing devices and illegal SYNC codes end
// the cycle with a bus abort (LFRAME# low with AD=1111 for 4 clocks).
//
// Ports:
//   lpc_clock  - bus clock, all state changes on the rising edge
//   lpc_reset  - asynchronous active-low reset
//   req_*      - request: valid/ready handshake, write flag, 16-bit address, 8-bit data
//   lpc_frame  - LFRAME#, active low
//   lpc_ad_*   - AD bus: host drive value, drive enable, sampled input
//   rsp_*      - one-clock completion pulse with read data, error and abort flags
module lpc_host_io #(
  parameter int SHORT_WAIT_MAX = 8,
  parameter int LONG_WAIT_MAX  = 0,
  parameter int NORESP_MAX     = 3
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        lpc_frame,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  input  logic [3:0]  lpc_ad_in,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_error,
  output logic        rsp_abort
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CTDIR, S_ADDR, S_WDATA, S_TAR1, S_TAR2,
    S_SYNC, S_RDATA, S_PTAR, S_DONE, S_ABORT
  } state_t;

  localparam logic [7:0] SHORT_LIM  = 8'(SHORT_WAIT_MAX);
  localparam logic [7:0] LONG_LIM   = 8'(LONG_WAIT_MAX);
  localparam logic [7:0] NORESP_LIM = 8'(NORESP_MAX);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        abt_q, abt_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        wlong_q, wlong_d;
  logic [7:0]  nresp_q, nresp_d;

  logic        frame_q, frame_d;
  logic [3:0]  ad_q, ad_d;
  logic        oe_q, oe_d;
  logic        ready_q, ready_d;
  logic        rvalid_q, rvalid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rerr_q, rerr_d;
  logic        rabt_q, rabt_d;

  logic        is_long;
  logic [7:0]  wait_next;
  logic [7:0]  nresp_next;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    abt_d      = abt_q;
    wcnt_d     = wcnt_q;
    wlong_d    = wlong_q;
    nresp_d    = nresp_q;
    is_long    = (lpc_ad_in == 4'b0110);
    wait_next  = 8'd0;
    nresp_next = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = S_START;
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_data;
          err_d   = 1'b0;
          abt_d   = 1'b0;
        end
      end
      S_START: state_d = S_CTDIR;
      S_CTDIR: begin
        state_d = S_ADDR;
        cnt_d   = 3'd0;
      end
      S_ADDR: begin
        if (cnt_q == 3'd3) begin
          cnt_d   = 3'd0;
          state_d = write_q ? S_WDATA : S_TAR1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WDATA: begin
        if (cnt_q == 3'd1) begin
          cnt_d   = 3'd0;
          state_d = S_TAR1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_TAR1: state_d = S_TAR2;
      S_TAR2: begin
        state_d = S_SYNC;
        wcnt_d  = 8'd0;
        nresp_d = 8'd0;
      end
      S_SYNC: begin
        case (lpc_ad_in)
          4'b0000, 4'b1010: begin
            if (lpc_ad_in == 4'b1010) err_d = 1'b1;
            cnt_d   = 3'd0;
            state_d = write_q ? S_PTAR : S_RDATA;
          end
          4'b0101, 4'b0110: begin
            // A run continues only while the wait type is unchanged.
            if (wcnt_q != 8'd0 && wlong_q == is_long)
              wait_next = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
            else
              wait_next = 8'd1;
            wcnt_d  = wait_next;
            wlong_d = is_long;
            nresp_d = 8'd0;
            if ((!is_long && wait_next > SHORT_LIM) ||
                (is_long && LONG_LIM != 8'd0 && wait_next > LONG_LIM)) begin
              state_d = S_ABORT;
              cnt_d   = 3'd0;
            end
          end
          4'b1111: begin
            wcnt_d     = 8'd0;
            nresp_next = nresp_q + 8'd1;
            nresp_d    = nresp_next;
            if (nresp_next == NORESP_LIM) begin
              state_d = S_ABORT;
              cnt_d   = 3'd0;
            end
          end
          default: begin
            state_d = S_ABORT;
            cnt_d   = 3'd0;
          end
        endcase
      end
      S_RDATA: begin
        if (cnt_q == 3'd0) begin
          rdata_d[3:0] = lpc_ad_in;
          cnt_d        = 3'd1;
        end else begin
          rdata_d[7:4] = lpc_ad_in;
          cnt_d        = 3'd0;
          state_d      = S_PTAR;
        end
      end
      S_PTAR: begin
        if (cnt_q == 3'd1) state_d = S_DONE;
        else               cnt_d   = 3'd1;
      end
      S_DONE: state_d = S_IDLE;
      S_ABORT: begin
        // Four clocks of LFRAME# low, then one clock high before completing.
        if (cnt_q == 3'd4) begin
          state_d = S_DONE;
          abt_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe.
    frame_d = !(state_d == S_START || (state_d == S_ABORT && cnt_d != 3'd4));
    oe_d    = state_d inside {S_START, S_CTDIR, S_ADDR, S_WDATA, S_TAR1, S_ABORT};
    ad_d    = 4'hF;
    case (state_d)
      S_START: ad_d = 4'h0;
      S_CTDIR: ad_d = {2'b00, write_d, 1'b0};
      S_ADDR: begin
        case (cnt_d[1:0])
          2'd0:    ad_d = addr_d[15:12];
          2'd1:    ad_d = addr_d[11:8];
          2'd2:    ad_d = addr_d[7:4];
          default: ad_d = addr_d[3:0];
        endcase
      end
      S_WDATA: ad_d = cnt_d[0] ? wdata_d[7:4] : wdata_d[3:0];
      default: ad_d = 4'hF;
    endcase
    ready_d    = (state_d == S_IDLE);
    rvalid_d   = (state_d == S_DONE);
    rerr_d     = rvalid_d && err_d && !abt_d;
    rabt_d     = rvalid_d && abt_d;
    rsp_data_d = rsp_data_q;
    if (rvalid_d && !write_d && !abt_d) rsp_data_d = rdata_d;
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      write_q    <= 1'b0;
      addr_q     <= 16'd0;
      wdata_q    <= 8'd0;
      rdata_q    <= 8'd0;
      err_q      <= 1'b0;
      abt_q      <= 1'b0;
      wcnt_q     <= 8'd0;
      wlong_q    <= 1'b0;
      nresp_q    <= 8'd0;
      frame_q    <= 1'b1;
      ad_q       <= 4'hF;
      oe_q       <= 1'b0;
      ready_q    <= 1'b1;
      rvalid_q   <= 1'b0;
      rsp_data_q <= 8'd0;
      rerr_q     <= 1'b0;
      rabt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      abt_q      <= abt_d;
      wcnt_q     <= wcnt_d;
      wlong_q    <= wlong_d;
      nresp_q    <= nresp_d;
      frame_q    <= frame_d;
      ad_q       <= ad_d;
      oe_q       <= oe_d;
      ready_q    <= ready_d;
      rvalid_q   <= rvalid_d;
      rsp_data_q <= rsp_data_d;
      rerr_q     <= rerr_d;
      rabt_q     <= rabt_d;
    end
  end

  assign req_ready  = ready_q;
  assign lpc_frame  = frame_q;
  assign lpc_ad_out = ad_q;
  assign lpc_ad_oe  = oe_q;
  assign rsp_valid  = rvalid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_error  = rerr_q;
  assign rsp_abort  = rabt_q;

endmodule

// File: tb/tb_lpc_host_io.sv
// tb/tb_lpc_host_io.sv - self-checking bench for lpc_host_io
module tb_lpc_host_io;

  localparam int SHORT_MAX  = 8;
  localparam int LONG_MAX   = 0;
  localparam int NORESP_CNT = 3;

  logic        lpc_clock = 1'b0;
  logic        lpc_reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr  = 16'd0;
  logic [7:0]  req_data  = 8'd0;
  logic        lpc_frame;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic [3:0]  lpc_ad_in = 4'hF;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_error;
  logic        rsp_abort;

  lpc_host_io #(
    .SHORT_WAIT_MAX(SHORT_MAX),
    .LONG_WAIT_MAX (LONG_MAX),
    .NORESP_MAX    (NORESP_CNT)
  ) dut (
    .lpc_clock (lpc_clock),
    .lpc_reset (lpc_reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .lpc_frame (lpc_frame),
    .lpc_ad_out(lpc_ad_out),
    .lpc_ad_oe (lpc_ad_oe),
    .lpc_ad_in (lpc_ad_in),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_error (rsp_error),
    .rsp_abort (rsp_abort)
  );

  always #5 lpc_clock = ~lpc_clock;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int last_done_cyc = 0;
  logic [7:0] exp_rdata = 8'd0;
  logic [3:0] sync_s[$];

  always @(posedge lpc_clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference SYNC decision: number of SYNC clocks and outcome (0 ok, 1 error, 2 abort).
  function automatic void sync_eval(output int n, output int kind);
    int run = 0;
    int nr  = 0;
    logic [3:0] wt = 4'h0;
    logic [3:0] x;
    n = 0;
    kind = 2;
    for (int i = 0; i < 64; i++) begin
      x = (i < sync_s.size()) ? sync_s[i] : 4'hF;
      n = i + 1;
      if (x == 4'h0) begin kind = 0; return; end
      else if (x == 4'hA) begin kind = 1; return; end
      else if (x == 4'h5 || x == 4'h6) begin
        if (wt == x) run++;
        else begin wt = x; run = 1; end
        nr = 0;
        if (x == 4'h5 && run > SHORT_MAX) begin kind = 2; return; end
        if (x == 4'h6 && LONG_MAX > 0 && run > LONG_MAX) begin kind = 2; return; end
      end else if (x == 4'hF) begin
        nr++;
        wt = 4'h0;
        run = 0;
        if (nr == NORESP_CNT) begin kind = 2; return; end
      end else begin
        kind = 2;
        return;
      end
    end
  endfunction

  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                         input logic [7:0] rd, input bit chain_in, input bit chain_out,
                         input string tag);
    int n, kind, len, s0, waitc;
    logic rdy;
    logic [5:0] e;
    logic [5:0] exp_q[$];
    logic [3:0] resp[$];
    logic [15:0] a;
    sync_eval(n, kind);
    // Expected host-side bus trace, {frame, oe, ad}; ad is 0 when not driven.
    exp_q.push_back({1'b0, 1'b1, 4'h0});
    exp_q.push_back({1'b1, 1'b1, wr ? 4'h2 : 4'h0});
    a = addr;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b1, 1'b1, a[15:12]});
      a = a << 4;
    end
    if (wr) begin
      exp_q.push_back({1'b1, 1'b1, data[3:0]});
      exp_q.push_back({1'b1, 1'b1, data[7:4]});
    end
    exp_q.push_back({1'b1, 1'b1, 4'hF});
    exp_q.push_back({1'b1, 1'b0, 4'h0});
    for (int k = 0; k < n; k++) exp_q.push_back({1'b1, 1'b0, 4'h0});
    if (kind == 2) begin
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 1'b1, 4'hF});
      exp_q.push_back({1'b1, 1'b1, 4'hF});
    end else begin
      if (!wr) for (int k = 0; k < 2; k++) exp_q.push_back({1'b1, 1'b0, 4'h0});
      for (int k = 0; k < 2; k++) exp_q.push_back({1'b1, 1'b0, 4'h0});
    end
    exp_q.push_back({1'b1, 1'b0, 4'h0});
    len = exp_q.size();

    // Peripheral responses per clock of the cycle.
    for (int k = 0; k < len; k++) resp.push_back(4'hF);
    s0 = wr ? 11 : 9;
    for (int k = 0; k < n; k++) resp[s0 - 1 + k] = (k < sync_s.size()) ? sync_s[k] : 4'hF;
    if (kind != 2 && !wr) begin
      resp[s0 - 1 + n] = rd[3:0];
      resp[s0 + n]     = rd[7:4];
    end

    @(posedge lpc_clock);
    #1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_data  = data;
    waitc = 0;
    do begin
      @(negedge lpc_clock);
      rdy = req_ready;
      @(posedge lpc_clock);
      waitc++;
    end while (!rdy && waitc < 50);
    check({tag, " accept"}, {31'd0, rdy}, 32'd1);
    if (!rdy) begin
      #1 req_valid = 1'b0;
      return;
    end

    for (int c = 1; c <= len; c++) begin
      if (c > 1) @(posedge lpc_clock);
      #1;
      if (c == 1) begin
        req_valid = 1'b0;
        if (chain_in) check({tag, " b2b_gap"}, {31'd0, (cyc - last_done_cyc) >= 2}, 32'd1);
      end
      lpc_ad_in = resp[c - 1];
      @(negedge lpc_clock);
      e = exp_q[c - 1];
      check($sformatf("%s c%0d bus", tag, c),
            {24'd0, req_ready, lpc_frame, lpc_ad_oe, lpc_ad_out & {4{lpc_ad_oe}}, rsp_valid},
            {24'd0, 1'b0, e, c == len});
      if (c == len) begin
        last_done_cyc = cyc;
        if (!wr && kind != 2) exp_rdata = rd;
        check({tag, " rsp_error"}, {31'd0, rsp_error}, {31'd0, kind == 1});
        check({tag, " rsp_abort"}, {31'd0, rsp_abort}, {31'd0, kind == 2});
        check({tag, " rsp_data"}, {24'd0, rsp_data}, {24'd0, exp_rdata});
      end
    end
    if (!chain_out) begin
      @(posedge lpc_clock);
      #1 lpc_ad_in = 4'hF;
      @(negedge lpc_clock);
      check({tag, " idle"}, {26'd0, req_ready, lpc_frame, lpc_ad_oe, rsp_valid, rsp_error, rsp_abort},
            {26'd0, 6'b110000});
    end
  endtask

  task automatic gen_sync(input int sc);
    int nw;
    logic [3:0] x;
    sync_s.delete();
    nw = $urandom_range(0, 5);
    if (sc == 5 || sc == 6) nw = 0;
    for (int k = 0; k < nw; k++) sync_s.push_back(($urandom % 2) ? 4'h5 : 4'h6);
    case (sc)
      0: sync_s.push_back(4'h0);
      1: sync_s.push_back(4'hA);
      2: begin
        do x = 4'($urandom_range(1, 14)); while (x == 4'h5 || x == 4'h6 || x == 4'hA);
        sync_s.push_back(x);
      end
      3: ;
      4: for (int k = 0; k < 9; k++) sync_s.push_back(4'h5);
      5: begin
        for (int k = 0; k < int'($urandom_range(10, 20)); k++) sync_s.push_back(4'h6);
        sync_s.push_back(4'h0);
      end
      default: begin
        for (int k = 0; k < int'($urandom_range(1, 2)); k++) sync_s.push_back(4'hF);
        sync_s.push_back(4'h5);
        sync_s.push_back(4'h0);
      end
    endcase
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit chained;
    bit nxt;
    #2 lpc_reset = 1'b0;
    repeat (3) @(posedge lpc_clock);
    @(negedge lpc_clock);
    check("reset_state",
          {13'd0, req_ready, lpc_frame, lpc_ad_oe, lpc_ad_out, rsp_valid, rsp_error, rsp_abort, rsp_data},
          {13'd0, 1'b1, 1'b1, 1'b0, 4'hF, 3'b000, 8'h00});
    lpc_reset = 1'b1;

    sync_s = '{4'h5, 4'h5, 4'h5, 4'h0};
    run_txn(1'b0, 16'h7FE5, 8'h00, 8'h6C, 1'b0, 1'b0, "t1_read");
    sync_s = '{4'h0};
    run_txn(1'b1, 16'h0080, 8'hA5, 8'h00, 1'b0, 1'b0, "t2_write");
    sync_s.delete();
    run_txn(1'b0, 16'h0060, 8'h00, 8'h00, 1'b0, 1'b0, "t3_noresp");
    sync_s = '{4'hA};
    run_txn(1'b0, 16'h03F8, 8'h00, 8'h11, 1'b0, 1'b0, "t4_error");
    sync_s = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5};
    run_txn(1'b0, 16'h03F8, 8'h00, 8'h22, 1'b0, 1'b0, "t4_shortwait");
    sync_s = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h0};
    run_txn(1'b0, 16'h1234, 8'h00, 8'h5A, 1'b0, 1'b0, "t4_8waits");

    // Reset in the middle of a write's address phase.
    @(posedge lpc_clock);
    #1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'hBEEF;
    req_data  = 8'h3C;
    @(posedge lpc_clock);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge lpc_clock);
    #3 lpc_reset = 1'b0;
    #1;
    exp_rdata = 8'h00;
    check("t5_reset_async",
          {13'd0, req_ready, lpc_frame, lpc_ad_oe, lpc_ad_out, rsp_valid, rsp_error, rsp_abort, rsp_data},
          {13'd0, 1'b1, 1'b1, 1'b0, 4'hF, 3'b000, 8'h00});
    for (int k = 0; k < 2; k++) begin
      @(negedge lpc_clock);
      check("t5_reset_hold", {29'd0, rsp_valid, lpc_frame, lpc_ad_oe}, {29'd0, 3'b010});
    end
    lpc_reset = 1'b1;
    sync_s = '{4'h6, 4'h0};
    run_txn(1'b1, 16'h00F0, 8'h96, 8'h00, 1'b0, 1'b0, "t5_after");

    sync_s = '{4'h0};
    run_txn(1'b0, 16'h0040, 8'h00, 8'h81, 1'b0, 1'b1, "t6_first");
    sync_s = '{4'h5, 4'h0};
    run_txn(1'b0, 16'h0041, 8'h00, 8'h7E, 1'b1, 1'b0, "t6_second");

    chained = 1'b0;
    for (int i = 0; i < 40; i++) begin
      gen_sync(int'($urandom_range(0, 6)));
      nxt = ($urandom % 4) == 0;
      run_txn(1'($urandom % 2), 16'($urandom), 8'($urandom), 8'($urandom),
              chained, nxt, $sformatf("rnd%0d", i));
      chained = nxt;
    end
    if (chained) begin
      @(posedge lpc_clock);
      @(negedge lpc_clock);
      check("rnd_tail_idle", {31'd0, req_ready}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
